vga_1bit_fetch: RTL and testbench

- Avalon-MM pipelined read master that streams a 1-bit-per-pixel frame buffer from memory into the write side of the VGA pixel FIFO.
- The 1-bit VGA display engine drains the FIFO on the read side.
- Per frame it fetches H_WORDS×V_LINES 16-bit words from a base address, in linear order.
- FIFO writes are throttled by a credit check, so the FIFO never overflows.

---
 rtl/vga_1bit_fetch_pkg.sv | 20 ++
 rtl/vga_fetch_credit.sv | 39 +++
 rtl/vga_1bit_fetch.sv | 140 ++++++++++++++
 tb/tb_vga_1bit_fetch.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_1bit_fetch_pkg.sv
// Shared definitions for the 1-bit VGA frame fetch engine.
// Display geometry, derived fetch sizes and FSM state encoding.
package vga_1bit_fetch_pkg;

    localparam int H_DISPLAY    = 640;
    localparam int V_DISPLAY    = 480;
    localparam int PIX_PER_WORD = 16;
    localparam int WORD_BYTES   = 2;

    localparam int H_WORDS_DFLT    = H_DISPLAY / PIX_PER_WORD;
    localparam int V_LINES_DFLT    = V_DISPLAY;
    localparam int FIFO_DEPTH_DFLT = 256;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/vga_fetch_credit.sv
// Combinational credit check and outstanding-read counter update.
// Credit is judged on next-cycle values so back-to-back issue stays safe.
module vga_fetch_credit #(
    parameter int FIFO_DEPTH  = 256,
    parameter int FIFO_MARGIN = 4,
    parameter int MAX_PEND    = 8,
    parameter int TOTAL       = 19200,
    parameter int USEDW_W     = 9,
    parameter int PEND_W      = 4,
    parameter int ISS_W       = 15
) (
    input  logic [USEDW_W-1:0] usedw,
    input  logic [PEND_W-1:0]  pending,
    input  logic               accept,
    input  logic               beat,
    input  logic [ISS_W-1:0]   issued_next,
    output logic [PEND_W-1:0]  pending_next,
    output logic               credit
);

    localparam logic [31:0] LIMIT = 32'(FIFO_DEPTH - FIFO_MARGIN);

    logic [31:0] fill;

    // Next pending count and whether one more read fits everywhere.
    always_comb begin
        pending_next = pending;
        if (accept && !beat) begin
            pending_next = pending + PEND_W'(1);
        end else if (!accept && beat && pending != '0) begin
            pending_next = pending - PEND_W'(1);
        end
        fill   = 32'(usedw) + 32'(pending_next) + 32'(beat);
        credit = (fill < LIMIT)
              && (pending_next < PEND_W'(MAX_PEND))
              && (issued_next < ISS_W'(TOTAL));
    end

endmodule

// File: rtl/vga_1bit_fetch.sv
// Avalon-MM pipelined read master filling the 1-bit VGA pixel FIFO.
// Fetches one frame of 16-bit words per frame_start, credit-throttled.
module vga_1bit_fetch
    import vga_1bit_fetch_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int H_WORDS     = H_WORDS_DFLT,
    parameter int V_LINES     = V_LINES_DFLT,
    parameter int FIFO_DEPTH  = FIFO_DEPTH_DFLT,
    parameter int FIFO_MARGIN = 4,
    parameter int MAX_PEND    = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          frame_start,
    input  logic [ADDR_W-1:0]             fb_base,
    output logic [ADDR_W-1:0]             avm_address,
    output logic                          avm_read,
    input  logic                          avm_waitrequest,
    input  logic [15:0]                   avm_readdata,
    input  logic                          avm_readdatavalid,
    output logic                          fifo_write_write,
    output logic [15:0]                   fifo_write_data,
    input  logic [$clog2(FIFO_DEPTH):0]   fifo_write_usedw,
    output logic                          busy,
    output logic                          frame_done,
    output logic                          frame_miss
);

    localparam int TOTAL   = H_WORDS * V_LINES;
    localparam int USEDW_W = $clog2(FIFO_DEPTH) + 1;
    localparam int PEND_W  = $clog2(MAX_PEND + 1);
    localparam int ISS_W   = $clog2(TOTAL + 1);

    state_t              state;
    logic [ISS_W-1:0]    issued;
    logic [ISS_W-1:0]    issued_next;
    logic [PEND_W-1:0]   pending;
    logic [PEND_W-1:0]   pending_next;
    logic                aborted;
    logic                accept;
    logic                beat;
    logic                last;
    logic                stalled;
    logic                credit;

    assign accept      = avm_read && !avm_waitrequest;
    assign stalled     = avm_read && avm_waitrequest;
    assign beat        = avm_readdatavalid && (state != ST_IDLE);
    assign issued_next = issued + ISS_W'(accept);
    assign last        = accept && (issued == ISS_W'(TOTAL - 1));

    vga_fetch_credit #(
        .FIFO_DEPTH  (FIFO_DEPTH),
        .FIFO_MARGIN (FIFO_MARGIN),
        .MAX_PEND    (MAX_PEND),
        .TOTAL       (TOTAL),
        .USEDW_W     (USEDW_W),
        .PEND_W      (PEND_W),
        .ISS_W       (ISS_W)
    ) u_credit (
        .usedw        (fifo_write_usedw),
        .pending      (pending),
        .accept       (accept),
        .beat         (beat),
        .issued_next  (issued_next),
        .pending_next (pending_next),
        .credit       (credit)
    );

    // Frame fetch FSM with registered Avalon, FIFO and status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= ST_IDLE;
            avm_read         <= 1'b0;
            avm_address      <= '0;
            fifo_write_write <= 1'b0;
            fifo_write_data  <= '0;
            busy             <= 1'b0;
            frame_done       <= 1'b0;
            frame_miss       <= 1'b0;
            issued           <= '0;
            pending          <= '0;
            aborted          <= 1'b0;
        end else begin
            fifo_write_write <= beat;
            if (beat) begin
                fifo_write_data <= avm_readdata;
            end
            frame_done <= 1'b0;
            frame_miss <= frame_start && (state != ST_IDLE);
            unique case (state)
                ST_IDLE: begin
                    if (frame_start && enable) begin
                        avm_address <= {fb_base[ADDR_W-1:1], 1'b0};
                        issued      <= '0;
                        pending     <= '0;
                        aborted     <= 1'b0;
                        busy        <= 1'b1;
                        state       <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    pending <= pending_next;
                    if (!stalled) begin
                        if (accept) begin
                            avm_address <= avm_address + ADDR_W'(WORD_BYTES);
                            issued      <= issued_next;
                        end
                        if (last) begin
                            avm_read <= 1'b0;
                            state    <= ST_DRAIN;
                        end else if (!enable) begin
                            avm_read <= 1'b0;
                            aborted  <= 1'b1;
                            state    <= ST_DRAIN;
                        end else begin
                            avm_read <= credit;
                        end
                    end
                end
                ST_DRAIN: begin
                    pending <= pending_next;
                    if (pending_next == '0 && !beat) begin
                        busy       <= 1'b0;
                        frame_done <= !aborted;
                        state      <= ST_IDLE;
                    end
                end
                default: begin
                    avm_read <= 1'b0;
                    busy     <= 1'b0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vga_1bit_fetch.sv
// Directed bench for vga_1bit_fetch with a small Avalon slave model.
// Frame is 4 words x 4 lines so the outstanding-read cap is exercised.
module tb_vga_1bit_fetch;

    localparam int HW  = 4;
    localparam int VL  = 4;
    localparam int TOT = HW * VL;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        frame_start;
    logic [31:0] fb_base;
    logic [31:0] avm_address;
    logic        avm_read;
    logic        avm_waitrequest = 1'b0;
    logic [15:0] avm_readdata = '0;
    logic        avm_readdatavalid = 1'b0;
    logic        fifo_write_write;
    logic [15:0] fifo_write_data;
    logic [8:0]  fifo_write_usedw;
    logic        busy;
    logic        frame_done;
    logic        frame_miss;

    always #5 clk = ~clk;

    vga_1bit_fetch #(
        .ADDR_W      (32),
        .H_WORDS     (HW),
        .V_LINES     (VL),
        .FIFO_DEPTH  (256),
        .FIFO_MARGIN (4),
        .MAX_PEND    (8)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .enable            (enable),
        .frame_start       (frame_start),
        .fb_base           (fb_base),
        .avm_address       (avm_address),
        .avm_read          (avm_read),
        .avm_waitrequest   (avm_waitrequest),
        .avm_readdata      (avm_readdata),
        .avm_readdatavalid (avm_readdatavalid),
        .fifo_write_write  (fifo_write_write),
        .fifo_write_data   (fifo_write_data),
        .fifo_write_usedw  (fifo_write_usedw),
        .busy              (busy),
        .frame_done        (frame_done),
        .frame_miss        (frame_miss)
    );

    typedef struct {
        int          due;
        logic [15:0] d;
    } beat_t;

    beat_t       rq[$];
    logic [31:0] addr_log[$];
    logic [15:0] data_log[$];
    logic [31:0] base_al = '0;
    logic [31:0] stall_addr = '0;
    int cyc = 0, acc_cnt = 0, beat_cnt = 0, wr_cnt = 0;
    int done_cnt = 0, miss_cnt = 0, last_wr_cyc = -1, done_cyc = -1;
    int max_pend = 0, lat = 2;
    int stall_req = -1, stall_left = 0, stall_seen = 0, stall_bad = 0;
    int fill_base = 0, fill_add = 0;
    bit fill_track = 1'b0;
    int nvec = 0, nbad = 0;

    assign fifo_write_usedw = 9'(fill_base + fill_add);

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nbad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // Slave model and output monitor, evaluated on the falling edge.
    always @(negedge clk) begin
        logic  w;
        beat_t b;
        cyc++;
        if (fifo_write_write) begin
            wr_cnt++;
            data_log.push_back(fifo_write_data);
            last_wr_cyc = cyc;
            if (fill_track) fill_add++;
        end
        if (frame_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (frame_miss) miss_cnt++;
        w = 1'b0;
        if (stall_left > 0 && acc_cnt == stall_req && avm_read) begin
            w = 1'b1;
            if (stall_seen == 0) stall_addr = avm_address;
            else if (avm_address != stall_addr) stall_bad++;
            stall_seen++;
            stall_left--;
        end else if (stall_seen > 0 && stall_left > 0) begin
            stall_bad++;
        end
        avm_waitrequest = w;
        if (avm_read && !w) begin
            acc_cnt++;
            addr_log.push_back(avm_address);
            b.due = cyc + lat;
            b.d   = 16'((avm_address - base_al) >> 1);
            rq.push_back(b);
        end
        if (rq.size() > 0 && rq[0].due <= cyc) begin
            avm_readdatavalid = 1'b1;
            avm_readdata      = rq[0].d;
            rq.pop_front();
            beat_cnt++;
        end else begin
            avm_readdatavalid = 1'b0;
            avm_readdata      = '0;
        end
        if (acc_cnt - beat_cnt > max_pend) max_pend = acc_cnt - beat_cnt;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic clr();
        acc_cnt = 0; beat_cnt = 0; wr_cnt = 0; done_cnt = 0; miss_cnt = 0;
        last_wr_cyc = -1; done_cyc = -1; max_pend = 0;
        stall_req = -1; stall_left = 0; stall_seen = 0; stall_bad = 0;
        addr_log.delete();
        data_log.delete();
    endtask

    task automatic start(input logic [31:0] base);
        fb_base     = base;
        base_al     = {base[31:1], 1'b0};
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
    endtask

    task automatic wait_idle(input int max);
        int n = 0;
        while (busy && n < max) begin
            step();
            n++;
        end
        chk("idle_timeout", 32'(busy), 32'd0);
        repeat (3) step();
    endtask

    task automatic wait_acc(input int k, input int max);
        int n = 0;
        while (acc_cnt < k && n < max) begin
            step();
            n++;
        end
        chk("acc_timeout", 32'(acc_cnt >= k), 32'd1);
    endtask

    task automatic frame_ok(input string tag, input int nw);
        chk({tag, "_nwords"}, 32'(data_log.size()), 32'(nw));
        chk({tag, "_naddr"}, 32'(addr_log.size()), 32'(nw));
        for (int i = 0; i < nw && i < data_log.size(); i++)
            chk({tag, "_data"}, 32'(data_log[i]), 32'(i));
        for (int i = 0; i < nw && i < addr_log.size(); i++)
            chk({tag, "_addr"}, addr_log[i], base_al + 32'(2 * i));
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; frame_start = 1'b0; fb_base = '0;
        clr();
        step(); step();
        chk("rst_read", 32'(avm_read), 32'd0);
        chk("rst_addr", avm_address, 32'd0);
        chk("rst_wr", 32'(fifo_write_write), 32'd0);
        chk("rst_wdata", 32'(fifo_write_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(frame_done), 32'd0);
        chk("rst_miss", 32'(frame_miss), 32'd0);
        reset = 1'b0;
        step();

        // ideal slave
        enable = 1'b1; clr(); lat = 2;
        start(32'h0000_1000);
        chk("busy_on", 32'(busy), 32'd1);
        wait_idle(200);
        frame_ok("ideal", TOT);
        chk("ideal_done", 32'(done_cnt), 32'd1);
        chk("ideal_done_t", 32'(done_cyc), 32'(last_wr_cyc + 1));
        chk("ideal_miss", 32'(miss_cnt), 32'd0);

        // 5-cycle stall on the third request, odd base
        clr(); stall_req = 2; stall_left = 5;
        start(32'h0000_2001);
        wait_idle(200);
        chk("stall_seen", 32'(stall_seen), 32'd5);
        chk("stall_bad", 32'(stall_bad), 32'd0);
        frame_ok("stall", TOT);
        chk("stall_done", 32'(done_cnt), 32'd1);

        // FIFO nearly full: one request only
        clr(); fill_base = 251; fill_add = 0; fill_track = 1'b1;
        start(32'h0000_3000);
        repeat (30) step();
        chk("full_acc", 32'(acc_cnt), 32'd1);
        chk("full_read", 32'(avm_read), 32'd0);
        chk("full_busy", 32'(busy), 32'd1);
        fill_track = 1'b0; fill_base = 0; fill_add = 0;
        wait_idle(200);
        frame_ok("full", TOT);
        chk("full_done", 32'(done_cnt), 32'd1);

        // long read latency: outstanding cap
        clr(); lat = 20;
        start(32'h0000_4000);
        wait_idle(400);
        chk("pend_le8", 32'(max_pend <= 8), 32'd1);
        frame_ok("lat20", TOT);
        lat = 2;

        // frame_start while busy, address wraps past 2^32
        clr();
        start(32'hFFFF_FFF8);
        repeat (3) step();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        wait_idle(200);
        chk("miss_cnt", 32'(miss_cnt), 32'd1);
        chk("miss_done", 32'(done_cnt), 32'd1);
        frame_ok("wrap", TOT);

        // abort after three accepts
        clr();
        start(32'h0000_5000);
        wait_acc(3, 50);
        enable = 1'b0;
        wait_idle(200);
        repeat (5) step();
        chk("abort_acc", 32'(acc_cnt), 32'd3);
        chk("abort_wr", 32'(wr_cnt), 32'd3);
        chk("abort_done", 32'(done_cnt), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        frame_ok("abort", 3);

        // start request while disabled is ignored
        clr();
        start(32'h0000_6000);
        repeat (5) step();
        chk("dis_busy", 32'(busy), 32'd0);
        chk("dis_acc", 32'(acc_cnt), 32'd0);
        chk("dis_miss", 32'(miss_cnt), 32'd0);

        // reset in the middle of a fetch
        enable = 1'b1; clr(); lat = 6;
        start(32'h0000_7000);
        wait_acc(3, 50);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mrst_read", 32'(avm_read), 32'd0);
        chk("mrst_addr", avm_address, 32'd0);
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_wr", 32'(fifo_write_write), 32'd0);
        repeat (20) step();
        chk("mrst_late_wr", 32'(wr_cnt), 32'd0);
        chk("mrst_idle", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
